// File: rtl/amber128_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : amber128_uart_tx
//  Description : 8N1 UART transmitter fed by the MMIO UART store strobe.
//                Bytes are buffered in a small FIFO and serialised LSB first
//                on tx_o. Ready keeps one slot spare for a byte that the
//                upstream stage has already committed.
//  Revision    : 1.0 - initial release
// ============================================================================
module amber128_uart_tx #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             tx_valid_i,
    input  logic [7:0]                       tx_data_i,
    output logic                             tx_ready_o,
    output logic                             tx_o,
    output logic                             busy_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level_o,
    output logic                             overflow_o
);

    localparam int c_CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int c_LVL_W        = $clog2(FIFO_DEPTH + 1);
    localparam int c_PTR_W        = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W        = (c_CLKS_PER_BIT < 2) ? 1 : $clog2(c_CLKS_PER_BIT);

    localparam logic [c_LVL_W-1:0] c_DEPTH_L   = c_LVL_W'(FIFO_DEPTH);
    localparam logic [c_LVL_W-1:0] c_READY_MAX = c_LVL_W'(FIFO_DEPTH - 2);
    localparam logic [c_CNT_W-1:0] c_CNT_END   = c_CNT_W'(c_CLKS_PER_BIT - 1);

    // Reject configurations the bit timing or pointer wrap cannot support
    generate
        if (c_CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("amber128_uart_tx: CLK_HZ/BAUD must be at least 2");
        end
        if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("amber128_uart_tx: FIFO_DEPTH must be a power of two, minimum 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_LVL_W-1:0]  r_level;
    logic [c_LVL_W-1:0]  w_level_nxt;
    logic                r_overflow;

    // Serialiser state
    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic [2:0]          r_bit_idx;
    logic [2:0]          w_bit_idx_nxt;
    logic [7:0]          r_shift;
    logic [7:0]          w_shift_nxt;
    logic                r_tx;
    logic                w_tx_nxt;

    logic                w_push;
    logic                w_pop;
    logic                w_drop;
    logic                w_fifo_nempty;
    logic                w_cnt_end;
    logic [7:0]          w_head;

    // A full FIFO drops the byte even if a pop frees a slot this cycle
    assign w_push        = tx_valid_i && (r_level != c_DEPTH_L);
    assign w_drop        = tx_valid_i && (r_level == c_DEPTH_L);
    assign w_fifo_nempty = (r_level != '0);
    assign w_cnt_end     = (r_cnt == c_CNT_END);
    assign w_head        = r_mem[r_rd_ptr];

    assign tx_ready_o   = (r_level <= c_READY_MAX);
    assign tx_o         = r_tx;
    assign busy_o       = (r_state != S_IDLE) || w_fifo_nempty;
    assign fifo_level_o = r_level;
    assign overflow_o   = r_overflow;

    // Byte storage; only read when the level says the slot is valid
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data_i;
        end
    end

    // Occupancy tracks push/pop directly so full and empty never alias
    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + c_LVL_W'(1);
        end else if (!w_push && w_pop) begin
            w_level_nxt = r_level - c_LVL_W'(1);
        end
    end

    // FIFO pointers, level and sticky overflow flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_level <= w_level_nxt;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Serialiser registers; tx_o idles high and snaps high on reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_tx      <= w_tx_nxt;
        end
    end

    // Frame sequencing: start bit, 8 data bits LSB first, stop bit
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_tx_nxt      = r_tx;
        w_pop         = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt     = '0;
                w_bit_idx_nxt = '0;
                w_tx_nxt      = 1'b1;
                if (w_fifo_nempty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_head;
                    w_state_nxt = S_START;
                    w_tx_nxt    = 1'b0;
                end
            end
            S_START: begin
                if (w_cnt_end) begin
                    w_cnt_nxt     = '0;
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = S_DATA;
                    w_tx_nxt      = r_shift[0];
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            S_DATA: begin
                if (w_cnt_end) begin
                    w_cnt_nxt = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_shift_nxt   = {1'b0, r_shift[7:1]};
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        w_tx_nxt      = r_shift[1];
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            S_STOP: begin
                if (w_cnt_end) begin
                    w_cnt_nxt = '0;
                    if (w_fifo_nempty) begin
                        // Chain straight into the next frame with no idle gap
                        w_pop       = 1'b1;
                        w_shift_nxt = w_head;
                        w_state_nxt = S_START;
                        w_tx_nxt    = 1'b0;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_tx_nxt    = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_amber128_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_amber128_uart_tx
//  Description : Self-checking bench for amber128_uart_tx (CLKS_PER_BIT=4,
//                FIFO depth 4). Frame-level reference model plus a line
//                decoder feeding a byte scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_amber128_uart_tx;

    localparam int CLK_HZ = 400;
    localparam int BAUD   = 100;
    localparam int C      = CLK_HZ / BAUD;
    localparam int DEPTH  = 4;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready_o;
    logic       tx_o;
    logic       busy_o;
    logic [2:0] fifo_level_o;
    logic       overflow_o;

    int total = 0;
    int bad   = 0;

    // Reference model: queued bytes, the byte on the line and its start edge
    int         n = 0;
    logic [7:0] m_q[$];
    logic [7:0] sb_q[$];
    logic [7:0] m_cur = 8'h00;
    bit         m_active = 1'b0;
    int         m_start = 0;
    bit         m_ovf = 1'b0;

    // Decoder results
    int         rx_starts[$];
    logic [7:0] rx_bytes[$];

    amber128_uart_tx #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .tx_valid_i   (tx_valid),
        .tx_data_i    (tx_data),
        .tx_ready_o   (tx_ready_o),
        .tx_o         (tx_o),
        .busy_o       (busy_o),
        .fifo_level_o (fifo_level_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected line level from the frame position of the current byte
    function automatic logic exp_tx();
        int k;
        int b;
        if (!m_active) return 1'b1;
        k = n - m_start;
        b = k / C;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_cur[b-1];
        return 1'b1;
    endfunction

    // Model update at each edge: a frame lasts 10*C edges, the next byte
    // starts on the edge the previous one ends, an idle line starts one
    // edge after a byte is queued; a full queue drops incoming bytes.
    initial begin
        int pre;
        forever begin
            @(posedge clk or negedge rst_ni);
            if (!rst_ni) begin
                m_q.delete();
                sb_q.delete();
                m_active = 1'b0;
                m_ovf    = 1'b0;
                m_start  = 0;
            end else begin
                n++;
                pre = m_q.size();
                if (m_active && (n == m_start + 10*C)) begin
                    if (pre > 0) begin
                        m_cur   = m_q.pop_front();
                        m_start = n;
                    end else begin
                        m_active = 1'b0;
                    end
                end else if (!m_active && pre > 0) begin
                    m_cur    = m_q.pop_front();
                    m_start  = n;
                    m_active = 1'b1;
                end
                if (tx_valid) begin
                    if (pre < DEPTH) begin
                        m_q.push_back(tx_data);
                        sb_q.push_back(tx_data);
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
        end
    end

    // Cycle-level comparison of every output against the model
    initial begin
        forever begin
            @(negedge clk);
            if (rst_ni) begin
                chk("tx_o", tx_o, exp_tx());
                chk("level", fifo_level_o, m_q.size());
                chk("ready", tx_ready_o, (m_q.size() <= DEPTH - 2));
                chk("busy", busy_o, (m_active || m_q.size() != 0));
                chk("overflow", overflow_o, m_ovf);
            end
        end
    end

    // Line decoder / scoreboard monitor: samples mid-bit, pops expected byte
    initial begin
        bit         rx_act;
        int         k;
        logic [9:0] fr;
        rx_act = 1'b0;
        k = 0;
        fr = '0;
        forever begin
            @(negedge clk or negedge rst_ni);
            if (!rst_ni) begin
                rx_act = 1'b0;
            end else if (!rx_act) begin
                if (tx_o === 1'b0) begin
                    rx_act = 1'b1;
                    k = 0;
                    fr = '0;
                    rx_starts.push_back(n);
                end
            end else begin
                k++;
                if ((k % C) == C/2) fr[k/C] = tx_o;
                if (k == 9*C + C/2) begin
                    rx_act = 1'b0;
                    chk("rx_start_bit", fr[0], 1'b0);
                    chk("rx_stop_bit", fr[9], 1'b1);
                    rx_bytes.push_back(fr[8:1]);
                    if (sb_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL rx_unexpected: got byte %02h expected none", fr[8:1]);
                    end else begin
                        chk("rx_byte", fr[8:1], sb_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        tx_valid = 1'b1;
        tx_data  = b;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    task automatic wait_idle(input int bound);
        int i;
        i = 0;
        while ((busy_o !== 1'b0 || m_active || m_q.size() != 0) && i < bound) begin
            step(1);
            i++;
        end
        if (i >= bound) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: busy after %0d cycles, expected idle", bound);
        end
    endtask

    task automatic wait_frames(input int cnt, input int bound);
        int i;
        i = 0;
        while (rx_starts.size() < cnt && i < bound) begin
            step(1);
            i++;
        end
        if (i >= bound) begin
            total++;
            bad++;
            $display("FAIL start_timeout: %0d frames started, expected %0d", rx_starts.size(), cnt);
        end
    endtask

    initial begin
        int a;
        int i;
        int s;
        // Reset state
        rst_ni = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", tx_o, 1'b1);
        chk("rst_level", fifo_level_o, 0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_ovf", overflow_o, 1'b0);
        chk("rst_ready", tx_ready_o, 1'b1);
        @(negedge clk);
        rst_ni = 1'b1;
        step(2);

        // Single byte: start bit on the second edge after valid is presented
        rx_starts.delete();
        push(8'hA5);
        a = n;
        wait_frames(1, 20);
        if (rx_starts.size() > 0) chk("first_fall_latency", rx_starts[0] - a, 1);
        s = (rx_starts.size() > 0) ? rx_starts[0] : 0;
        wait_idle(200);
        chk("busy_after_fall", n - s, 40);
        step(3);

        // Back-to-back: three frames, no idle gap
        rx_starts.delete();
        push(8'h00);
        push(8'hFF);
        push(8'h55);
        wait_idle(400);
        chk("b2b_frames", rx_starts.size(), 3);
        if (rx_starts.size() == 3) begin
            chk("b2b_span", n - rx_starts[0], 120);
            chk("b2b_gap", rx_starts[2] - rx_starts[1], 40);
        end
        step(3);

        // Back-pressure, then overflow with a full FIFO
        rx_starts.delete();
        push(8'h11);
        wait_frames(1, 20);
        push(8'h22);
        push(8'h33);
        chk("bp_ready_at2", tx_ready_o, 1'b1);
        push(8'h44);
        chk("bp_ready_at3", tx_ready_o, 1'b0);
        push(8'h55);
        chk("bp_level_full", fifo_level_o, 4);
        chk("bp_ovf_clear", overflow_o, 1'b0);
        push(8'h99);
        chk("ovf_set", overflow_o, 1'b1);
        chk("ovf_level", fifo_level_o, 4);
        i = 0;
        while (fifo_level_o != 3'd2 && i < 200) begin
            step(1);
            i++;
        end
        chk("bp_ready_back", tx_ready_o, 1'b1);
        wait_idle(400);
        chk("ovf_sticky", overflow_o, 1'b1);
        chk("ovf_sb_empty", sb_q.size(), 0);
        step(3);

        // Reset during data bit 3 of 0x3C with two bytes queued
        rx_starts.delete();
        push(8'h3C);
        push(8'h5A);
        push(8'hC3);
        wait_frames(1, 20);
        s = (rx_starts.size() > 0) ? rx_starts[0] : n;
        i = 0;
        while (n < s + 4*C + 1 && i < 100) begin
            step(1);
            i++;
        end
        #2;
        rst_ni = 1'b0;
        #1;
        chk("midrst_tx", tx_o, 1'b1);
        chk("midrst_level", fifo_level_o, 0);
        chk("midrst_busy", busy_o, 1'b0);
        chk("midrst_ovf", overflow_o, 1'b0);
        @(negedge clk);
        rst_ni = 1'b1;
        step(2);
        rx_bytes.delete();
        push(8'h81);
        wait_idle(200);
        chk("post_rst_frames", rx_bytes.size(), 1);
        if (rx_bytes.size() > 0) chk("post_rst_byte", rx_bytes[0], 8'h81);
        step(3);

        // Wrap-around: ten bytes through the depth-4 FIFO, honouring ready
        rx_bytes.delete();
        for (int b = 0; b < 10; b++) begin
            i = 0;
            while (!tx_ready_o && i < 200) begin
                step(1);
                i++;
            end
            push(8'(b));
        end
        wait_idle(1000);
        chk("wrap_count", rx_bytes.size(), 10);
        for (int b = 0; b < 10 && b < rx_bytes.size(); b++) begin
            chk("wrap_order", rx_bytes[b], 8'(b));
        end
        step(3);

        // Random traffic, occasionally ignoring ready to provoke drops
        for (int r = 0; r < 40; r++) begin
            step($urandom_range(0, 6));
            if (tx_ready_o || $urandom_range(0, 9) == 0) push(8'($urandom));
        end
        wait_idle(4000);
        chk("rand_sb_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
